// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed common-anode 7-segment driver. A load strobe
//               captures a packed nibble word into a shadow buffer. The
//               buffer is copied to the display buffer only at a frame
//               boundary, so a scanned frame never mixes two values. The
//               driver decodes BCD or hex glyphs, drives per-digit decimal
//               points and can suppress leading zeros. Segment, decimal-point
//               and anode lines are active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int DIGITS = 4,   // number of scanned digits (1..8)
  parameter int DIV    = 1000 // clock cycles each digit stays lit (>=1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                hex_mode,
  input  logic                lz_blank,
  input  logic                load,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   dp_in,
  output logic                pending,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   an
);

  // Counter widths never collapse to zero bits, so DIV=1 and DIGITS=1 both
  // remain legal.
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;

  // --------------------------------------------------------------------------
  // Glyph decoder: segments a..g on bits [6:0], active-low. In BCD mode the
  // codes 10..15 have no glyph and render blank.
  // --------------------------------------------------------------------------
  function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
    logic [6:0] g;
    g = SEG_BLANK;
    case (nib)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0001100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      4'hF: g = 7'b0111000;
    endcase
    if (!hex && (nib > 4'd9)) begin
      g = SEG_BLANK;
    end
    return g;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]    cnt_q,          cnt_d;
  logic [IDX_W-1:0]    idx_q,          idx_d;
  logic [4*DIGITS-1:0] shadow_data_q,  shadow_data_d;
  logic [DIGITS-1:0]   shadow_dp_q,    shadow_dp_d;
  logic [4*DIGITS-1:0] disp_data_q,    disp_data_d;
  logic [DIGITS-1:0]   disp_dp_q,      disp_dp_d;
  logic                pending_q,      pending_d;
  logic [6:0]          seg_q,          seg_d;
  logic                dp_q,           dp_d;
  logic [DIGITS-1:0]   an_q,           an_d;

  // Combinational helpers
  logic                tick;
  logic                frame_end;
  logic [3:0]          disp_nib [DIGITS];
  logic [DIGITS-1:0]   lz_mask;
  logic [DIGITS-1:0]   digit_sel;
  logic [3:0]          cur_nib;

  // Prescaler tick and frame boundary (last digit finishing its time slot).
  always_comb begin
    tick      = (cnt_q == CNT_MAX);
    frame_end = enable && tick && (idx_q == IDX_LAST);
  end

  // Prescaler and digit index; both parked at 0 while scanning is disabled
  // so that re-enabling always restarts from digit 0.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Double buffer: a load always lands in the shadow and marks it pending.
  // A pending shadow moves to the display buffer at a frame boundary, or at
  // once when the display is blanked (no frame can tear while nothing is lit).
  // A load on the transfer edge wins the pending flag, so that value waits
  // for the next boundary.
  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    disp_data_d   = disp_data_q;
    disp_dp_d     = disp_dp_q;
    pending_d     = pending_q;
    if (pending_q && (frame_end || !enable)) begin
      disp_data_d = shadow_data_q;
      disp_dp_d   = shadow_dp_q;
      pending_d   = 1'b0;
    end
    if (load) begin
      shadow_data_d = data;
      shadow_dp_d   = dp_in;
      pending_d     = 1'b1;
    end
  end

  // Split the display word into per-digit nibbles.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      disp_nib[i] = disp_data_q[4*i +: 4];
    end
  end

  // Leading-zero mask: walking down from the most significant digit, a digit
  // is suppressed while it and every digit above it are zero. Digit 0 always
  // shows.
  always_comb begin
    logic run_zero;
    run_zero = 1'b1;
    lz_mask  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run_zero   = run_zero & (disp_nib[i] == 4'd0);
      lz_mask[i] = run_zero & lz_blank;
    end
  end

  // Next values for the registered display lines of the digit now selected.
  // Suppressed or undecodable digits still show their decimal point.
  always_comb begin
    cur_nib   = disp_nib[idx_q];
    digit_sel = '0;
    seg_d     = SEG_BLANK;
    dp_d      = 1'b1;
    an_d      = '1;
    if (enable) begin
      digit_sel[idx_q] = 1'b1;
      an_d             = ~digit_sel;
      seg_d            = lz_mask[idx_q] ? SEG_BLANK : glyph(cur_nib, hex_mode);
      dp_d             = ~disp_dp_q[idx_q];
    end
  end

  // All state and outputs; asynchronous reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      disp_data_q   <= '0;
      disp_dp_q     <= '0;
      pending_q     <= 1'b0;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      an_q          <= '1;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      disp_data_q   <= disp_data_d;
      disp_dp_q     <= disp_dp_d;
      pending_q     <= pending_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign pending = pending_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign an      = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver (DIGITS=4, DIV=4).
//               Directed scenarios followed by random stimulus, all compared
//               against a cycle-position reference model of the display.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        enable   = 1'b0;
  logic        hex_mode = 1'b0;
  logic        lz_blank = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] data     = '0;
  logic [3:0]  dp_in    = '0;
  logic        pending;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pos = cycles since scanning (re)started
  int          pos;
  bit          m_pending;
  logic [15:0] m_sh_data, m_disp_data;
  logic [3:0]  m_sh_dp,   m_disp_dp;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_pending;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .hex_mode (hex_mode),
    .lz_blank (lz_blank),
    .load     (load),
    .data     (data),
    .dp_in    (dp_in),
    .pending  (pending),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("seg",     32'(seg),     32'(e_seg));
    check_eq("dp",      32'(dp),      32'(e_dp));
    check_eq("an",      32'(an),      32'(e_an));
    check_eq("pending", 32'(pending), 32'(e_pending));
  endtask

  task automatic model_reset();
    pos         = 0;
    m_pending   = 0;
    m_sh_data   = '0;
    m_disp_data = '0;
    m_sh_dp     = '0;
    m_disp_dp   = '0;
    e_seg       = 7'h7F;
    e_dp        = 1'b1;
    e_an        = 4'hF;
    e_pending   = 1'b0;
  endtask

  // Predict the effect of the coming rising edge from the driven inputs.
  task automatic model_step();
    int         d;
    logic [3:0] nib;
    bit         suppressed;
    bit         boundary;
    d          = (pos / DIV) % DIGITS;
    nib        = 4'(m_disp_data >> (4 * d));
    suppressed = lz_blank && (d > 0) && ((m_disp_data >> (4 * d)) == 16'd0);
    if (!enable) begin
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_an  = 4'hF;
    end else begin
      e_seg = (suppressed || (!hex_mode && nib > 4'd9)) ? 7'h7F : GLYPH[nib];
      e_dp  = ~m_disp_dp[d];
      e_an  = ~(4'b0001 << d);
    end
    boundary = enable && ((pos % FRAME) == FRAME - 1);
    if (m_pending && (boundary || !enable)) begin
      m_disp_data = m_sh_data;
      m_disp_dp   = m_sh_dp;
      m_pending   = 0;
    end
    if (load) begin
      m_sh_data = data;
      m_sh_dp   = dp_in;
      m_pending = 1;
    end
    e_pending = m_pending;
    pos       = enable ? pos + 1 : 0;
  endtask

  // One clock: check the previous edge's result, then drive the next inputs.
  task automatic cyc(input bit en, input bit hx, input bit lz, input bit ld,
                     input logic [15:0] d, input logic [3:0] p);
    @(negedge clk);
    check_outputs();
    rst_n    = 1'b1;
    enable   = en;
    hex_mode = hx;
    lz_blank = lz;
    load     = ld;
    data     = d;
    dp_in    = p;
    model_step();
  endtask

  task automatic idle(input int n, input bit en, input bit hx, input bit lz);
    repeat (n) cyc(en, hx, lz, 1'b0, data, dp_in);
  endtask

  // Run with scanning enabled until the next edge sits at the given frame phase.
  task automatic goto_phase(input int phase, input bit hx, input bit lz);
    int guard = 0;
    while (((pos % FRAME) != phase) && (guard < 2 * FRAME)) begin
      cyc(1'b1, hx, lz, 1'b0, data, dp_in);
      guard++;
    end
    check_eq("phase_reached", 32'(pos % FRAME), 32'(phase));
  endtask

  task automatic load_at(input int phase, input bit hx, input bit lz,
                         input logic [15:0] d, input logic [3:0] p);
    goto_phase(phase, hx, lz);
    cyc(1'b1, hx, lz, 1'b1, d, p);
  endtask

  // Asynchronous reset asserted between clock edges and held two cycles.
  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit          r_en, r_hx, r_lz;
    logic [15:0] r_data;

    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();                               // reset state

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);   // release reset
    idle(FRAME + 2, 1'b1, 1'b0, 1'b0);             // zeros on every digit

    goto_phase(2 * DIV + 1, 1'b0, 1'b0);           // reset during digit 2
    do_reset();
    idle(FRAME, 1'b1, 1'b0, 1'b0);

    load_at(5, 1'b0, 1'b0, 16'h1234, 4'b0010);
    idle(3 * FRAME, 1'b1, 1'b0, 1'b0);

    load_at(0, 1'b0, 1'b0, 16'hABCD, 4'b0000);
    idle(2 * FRAME, 1'b1, 1'b0, 1'b0);             // BCD: all blank
    idle(2 * FRAME, 1'b1, 1'b1, 1'b0);             // hex glyphs

    load_at(3, 1'b1, 1'b1, 16'h0050, 4'b1000);
    idle(2 * FRAME, 1'b1, 1'b1, 1'b1);
    load_at(3, 1'b1, 1'b1, 16'h0000, 4'b0000);
    idle(2 * FRAME, 1'b1, 1'b1, 1'b1);

    load_at(DIV, 1'b0, 1'b0, 16'h1111, 4'b0001);   // overwritten while pending
    load_at(2 * DIV, 1'b0, 1'b0, 16'h2222, 4'b0100);
    idle(2 * FRAME, 1'b1, 1'b0, 1'b0);

    load_at(FRAME - 1, 1'b0, 1'b0, 16'h9876, 4'hF); // coincides with boundary
    idle(3 * FRAME, 1'b1, 1'b0, 1'b0);

    goto_phase(DIV + 1, 1'b0, 1'b0);               // disable during digit 1
    idle(3, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h4321, 4'h1);   // load while blanked
    idle(2, 1'b0, 1'b0, 1'b0);
    idle(2 * FRAME, 1'b1, 1'b0, 1'b0);

    r_en = 1'b1;
    r_hx = 1'b0;
    r_lz = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) r_en = ~r_en;
      if (!r_en && $urandom_range(0, 3) == 0) r_en = 1'b1;
      if ($urandom_range(0, 149) == 0) r_hx = ~r_hx;
      if ($urandom_range(0, 149) == 0) r_lz = ~r_lz;
      for (int k = 0; k < DIGITS; k++) begin
        r_data[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      end
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end
      cyc(r_en, r_hx, r_lz, ($urandom_range(0, 11) == 0), r_data, 4'($urandom));
    end
    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
